// File: rtl/rv_mem_arbiter.sv
// rv_mem_arbiter: shares one memory bus between instruction fetch (F) and
// the load/store path (D). One transaction at a time: grant, address phase,
// data phase, registered response. D has priority, bounded by a starvation
// counter; fetch flush drops stale fetch responses; a timeout aborts hung
// bus transactions.
module rv_mem_arbiter #(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned DATA_STARVE_MAX = 4,
    parameter int unsigned TIMEOUT_CYC     = 64
) (
    input  logic              clk,
    input  logic              rst,
    // fetch port
    input  logic              f_req_vld,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_req_rdy,
    input  logic              f_flush,
    output logic              f_rsp_vld,
    output logic [DATA_W-1:0] f_rsp_data,
    // load/store port
    input  logic              d_req_vld,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_we,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_req_rdy,
    output logic              d_rsp_vld,
    output logic [DATA_W-1:0] d_rsp_data,
    output logic              rsp_err,
    // memory bus
    output logic              mem_addr_vld,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_addr_rsp,
    output logic              mem_wdata_vld,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_data_rsp
);

    localparam int unsigned StarveW = $clog2(DATA_STARVE_MAX + 1);
    localparam int unsigned TmoW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [StarveW-1:0] StarveMax = StarveW'(DATA_STARVE_MAX);
    localparam logic [StarveW-1:0] StarveOne = StarveW'(1);
    // tmo_q counts busy cycles already spent, so the last allowed one is TIMEOUT_CYC-1
    localparam logic [TmoW-1:0]    TmoLast   = TmoW'(TIMEOUT_CYC - 1);
    localparam logic [TmoW-1:0]    TmoOne    = TmoW'(1);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;
    typedef enum logic {OwnF, OwnD} owner_e;

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [StarveW-1:0]  starve_q, starve_d;
    logic [TmoW-1:0]     tmo_q, tmo_d;
    logic                drop_q, drop_d;
    logic                f_rsp_vld_q, f_rsp_vld_d;
    logic                d_rsp_vld_q, d_rsp_vld_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;

    logic                tmo_hit;
    logic                drop_now;
    logic                fin;
    logic                fin_err;
    logic [DATA_W-1:0]   fin_data;

    // Next-state, grant and bus-phase outputs
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        addr_d        = addr_q;
        we_d          = we_q;
        wdata_d       = wdata_q;
        starve_d      = starve_q;
        tmo_d         = '0;
        drop_d        = drop_q;
        f_rsp_vld_d   = 1'b0;
        d_rsp_vld_d   = 1'b0;
        rsp_data_d    = '0;
        rsp_err_d     = 1'b0;
        f_req_rdy     = 1'b0;
        d_req_rdy     = 1'b0;
        mem_addr_vld  = 1'b0;
        mem_wdata_vld = 1'b0;
        fin           = 1'b0;
        fin_err       = 1'b0;
        fin_data      = '0;

        tmo_hit  = (TIMEOUT_CYC != 0) && (tmo_q == TmoLast);
        // A flush in the final busy cycle must still suppress the fetch response
        drop_now = drop_q | (f_flush & (owner_q == OwnF));

        unique case (state_q)
            StIdle: begin
                drop_d    = 1'b0;
                d_req_rdy = !rst && d_req_vld && !(f_req_vld && (starve_q == StarveMax));
                f_req_rdy = !rst && f_req_vld && !f_flush && !d_req_rdy;
                if (d_req_rdy) begin
                    owner_d = OwnD;
                    addr_d  = d_addr;
                    we_d    = d_we;
                    wdata_d = d_wdata;
                    state_d = StAddr;
                    if (f_req_vld) begin
                        if (starve_q != StarveMax) starve_d = starve_q + StarveOne;
                    end else begin
                        starve_d = '0;
                    end
                end else if (f_req_rdy) begin
                    owner_d  = OwnF;
                    addr_d   = f_addr;
                    we_d     = 1'b0;
                    wdata_d  = '0;
                    starve_d = '0;
                    state_d  = StAddr;
                end
            end
            StAddr: begin
                mem_addr_vld  = 1'b1;
                mem_wdata_vld = we_q;
                drop_d        = drop_now;
                if (tmo_hit) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else begin
                    tmo_d = tmo_q + TmoOne;
                    if (mem_addr_rsp) state_d = StData;
                end
            end
            StData: begin
                drop_d = drop_now;
                // A real completion wins over a timeout landing in the same cycle
                if (mem_data_rsp) begin
                    fin      = 1'b1;
                    fin_data = we_q ? '0 : mem_rdata;
                end else if (tmo_hit) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else begin
                    tmo_d = tmo_q + TmoOne;
                end
            end
            default: state_d = StIdle;
        endcase

        if (fin) begin
            state_d = StIdle;
            drop_d  = 1'b0;
            if (owner_q == OwnD) begin
                d_rsp_vld_d = 1'b1;
                rsp_data_d  = fin_data;
                rsp_err_d   = fin_err;
            end else if (!drop_now) begin
                f_rsp_vld_d = 1'b1;
                rsp_data_d  = fin_data;
                rsp_err_d   = fin_err;
            end
        end
    end

    // State and response registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            owner_q     <= OwnF;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            starve_q    <= '0;
            tmo_q       <= '0;
            drop_q      <= 1'b0;
            f_rsp_vld_q <= 1'b0;
            d_rsp_vld_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            starve_q    <= starve_d;
            tmo_q       <= tmo_d;
            drop_q      <= drop_d;
            f_rsp_vld_q <= f_rsp_vld_d;
            d_rsp_vld_q <= d_rsp_vld_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign f_rsp_vld  = f_rsp_vld_q;
    assign d_rsp_vld  = d_rsp_vld_q;
    assign f_rsp_data = rsp_data_q;
    assign d_rsp_data = rsp_data_q;
    assign rsp_err    = rsp_err_q;

endmodule
